// File: rtl/muldiv_seq_if.sv
// Bundle between the pipeline/ALU side and the MULTU/DIVU sequencer.
interface muldiv_seq_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              flush;
  logic              hi_wr_en;
  logic              lo_wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              alu_sel;
  logic [DATA_W-1:0] alu_op_1;
  logic [DATA_W-1:0] alu_op_2;
  logic [3:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  // Pipeline and shared ALU side.
  modport master (
    output start, op, src_a, src_b, flush, hi_wr_en, lo_wr_en, wr_data,
    output alu_result, alu_carry,
    input  alu_sel, alu_op_1, alu_op_2, alu_ctrl, busy, done, hi, lo
  );

  // Sequencer side.
  modport slave (
    input  start, op, src_a, src_b, flush, hi_wr_en, lo_wr_en, wr_data,
    input  alu_result, alu_carry,
    output alu_sel, alu_op_1, alu_op_2, alu_ctrl, busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative unsigned MULTU/DIVU sequencer borrowing the EX-stage ALU.
// state | meaning
// IDLE  | ALU free, MTHI/MTLO accepted, waiting for start
// RUN   | owns ALU, one shift-add / restoring-subtract step per cycle
// DONE  | result committed to HI/LO, done pulse
module muldiv_seq #(
  parameter int          DATA_W  = 32,
  parameter logic [3:0]  ALU_ADD = 4'b0010,
  parameter logic [3:0]  ALU_SUB = 4'b0110
) (
  input  logic           clk,
  input  logic           rst,
  muldiv_seq_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_hi, acc_lo, m;
  logic [DATA_W-1:0] acc_hi_nxt, acc_lo_nxt;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic [DATA_W-1:0] sh;
  logic [4:0]        cnt;
  logic              op_q;
  logic              q;
  logic              last_iter;

  assign last_iter = (cnt == 5'd31);
  assign bus.busy  = (state_q == RUN) || (state_q == DONE);
  assign bus.done  = (state_q == DONE);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush overrides everything, including a start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  // ALU mux drive and the per-iteration accumulator update.
  always_comb begin
    bus.alu_sel  = 1'b0;
    bus.alu_ctrl = 4'b0000;
    bus.alu_op_1 = '0;
    bus.alu_op_2 = '0;
    acc_hi_nxt   = acc_hi;
    acc_lo_nxt   = acc_lo;
    sh           = {acc_hi[DATA_W-2:0], acc_lo[DATA_W-1]};
    // A set top bit means the shifted remainder exceeds 32 bits, so the
    // subtract always fits even though the ALU reports a borrow.
    q            = acc_hi[DATA_W-1] | ~bus.alu_carry;
    if (state_q == RUN) begin
      bus.alu_sel = 1'b1;
      if (op_q) begin
        bus.alu_ctrl = ALU_SUB;
        bus.alu_op_1 = sh;
        bus.alu_op_2 = m;
        acc_hi_nxt   = q ? bus.alu_result : sh;
        acc_lo_nxt   = {acc_lo[DATA_W-2:0], q};
      end else begin
        bus.alu_ctrl = ALU_ADD;
        bus.alu_op_1 = acc_hi;
        bus.alu_op_2 = acc_lo[0] ? m : '0;
        acc_hi_nxt   = {bus.alu_carry, bus.alu_result[DATA_W-1:1]};
        acc_lo_nxt   = {bus.alu_result[0], acc_lo[DATA_W-1:1]};
      end
    end
  end

  // Operand capture, iteration, commit, and MTHI/MTLO writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_hi <= '0;
      acc_lo <= '0;
      m      <= '0;
      cnt    <= '0;
      op_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.hi_wr_en) hi_q <= bus.wr_data;
          if (bus.lo_wr_en) lo_q <= bus.wr_data;
          if (bus.start && !bus.flush) begin
            acc_hi <= '0;
            acc_lo <= bus.src_a;
            m      <= bus.src_b;
            cnt    <= '0;
            op_q   <= bus.op;
          end
        end
        RUN: begin
          acc_hi <= acc_hi_nxt;
          acc_lo <= acc_lo_nxt;
          cnt    <= cnt + 5'd1;
          if (last_iter && !bus.flush) begin
            hi_q <= acc_hi_nxt;
            lo_q <= acc_lo_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
